// File: rtl/change_dispenser_if.sv
// Dispense channel between the change dispenser and the hopper driver.
// One record per transfer: denomination index plus unit count, valid/ready handshake.
interface change_dispenser_if #(
  parameter int unsigned COUNT_W = 8
);
  logic               disp_valid;
  logic [2:0]         disp_idx;
  logic [COUNT_W-1:0] disp_count;
  logic               disp_ready;

  modport master (
    output disp_valid,
    output disp_idx,
    output disp_count,
    input  disp_ready
  );

  modport slave (
    input  disp_valid,
    input  disp_idx,
    input  disp_count,
    output disp_ready
  );
endinterface

// File: rtl/change_dispenser.sv
// Breaks an accepted change amount into denomination records, largest first,
// by repeated subtraction; one compare/subtract per cycle, records over a handshake.
module change_dispenser #(
  parameter logic [15:0] DENOM0  = 16'd10000,
  parameter logic [15:0] DENOM1  = 16'd5000,
  parameter logic [15:0] DENOM2  = 16'd1000,
  parameter logic [15:0] DENOM3  = 16'd500,
  parameter logic [15:0] DENOM4  = 16'd100,
  parameter logic [15:0] DENOM5  = 16'd50,
  parameter logic [15:0] DENOM6  = 16'd10,
  parameter logic [15:0] DENOM7  = 16'd1,
  parameter int unsigned COUNT_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic                i_paid,
  input  logic [15:0]         i_change,
  change_dispenser_if.master  disp,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic                o_overrun
);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    EMIT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        rem_q, rem_d;
  logic [2:0]         idx_q, idx_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic               busy_d, done_d, error_d, overrun_d, dvalid_d;
  logic [2:0]         didx_d;
  logic [COUNT_W-1:0] dcount_d;
  logic               busy_q, done_q, error_q, overrun_q, dvalid_q;
  logic [2:0]         didx_q;
  logic [COUNT_W-1:0] dcount_q;

  logic [15:0]        denom;
  logic               rem_ge, rem_zero, cnt_full, cnt_zero, last_idx;

  always_comb begin
    case (idx_q)
      3'd0:    denom = DENOM0;
      3'd1:    denom = DENOM1;
      3'd2:    denom = DENOM2;
      3'd3:    denom = DENOM3;
      3'd4:    denom = DENOM4;
      3'd5:    denom = DENOM5;
      3'd6:    denom = DENOM6;
      default: denom = DENOM7;
    endcase
  end

  assign rem_ge   = (rem_q >= denom);
  assign rem_zero = (rem_q == '0);
  assign cnt_full = (cnt_q == '1);
  assign cnt_zero = (cnt_q == '0);
  assign last_idx = (idx_q == 3'd7);

  // State, datapath and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
      dvalid_q  <= 1'b0;
      didx_q    <= '0;
      dcount_q  <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
      dvalid_q  <= dvalid_d;
      didx_q    <= didx_d;
      dcount_q  <= dcount_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          idx_d = '0;
          cnt_d = '0;
          if (i_paid && (i_change != '0)) begin
            rem_d   = i_change;
            state_d = DIVIDE;
          end else begin
            // clear any residual left by an earlier unpayable amount so o_error stays low
            rem_d   = '0;
            state_d = DONE;
          end
        end
      end
      DIVIDE: begin
        if (rem_ge) begin
          if (!cnt_full) begin
            rem_d = rem_q - denom;
            cnt_d = cnt_q + COUNT_W'(1);
          end else begin
            state_d = EMIT;
          end
        end else if (!cnt_zero) begin
          state_d = EMIT;
        end else if (rem_zero || last_idx) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      EMIT: begin
        if (disp.disp_ready) begin
          cnt_d = '0;
          if (rem_ge) begin
            state_d = DIVIDE;
          end else if (rem_zero || last_idx) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = DIVIDE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they track state_q exactly
  always_comb begin
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    error_d   = (state_d == DONE) && (rem_d != '0);
    overrun_d = i_valid && (state_q != IDLE);
    dvalid_d  = (state_d == EMIT);
    didx_d    = (state_d == EMIT) ? idx_d : '0;
    dcount_d  = (state_d == EMIT) ? cnt_d : '0;
  end

  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_error         = error_q;
  assign o_overrun       = overrun_q;
  assign disp.disp_valid = dvalid_q;
  assign disp.disp_idx   = didx_q;
  assign disp.disp_count = dcount_q;

endmodule
